// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs symbolic MIPS instruction requests into 32-bit
// R/I/J words and writes them into consecutive instruction-memory words
// starting at address 0.
// Optional feature macro: ENC_ILLEGAL_TRAP_EN. When it is defined, illegal kinds
// set a sticky err flag and are not written. When it is undefined, illegal kinds
// are written as a NOP and err is tied low.
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     count_inc;
    logic [31:0]         encoded;
    logic                accept;
    logic                write_en;

    // Pack the request fields into the opcode/funct layout the core decodes
    always_comb begin
        encoded = 32'h0000_0000;
        unique case (kind)
            4'd0:    encoded = {6'b100011, rs, rt, imm};
            4'd1:    encoded = {6'b101011, rs, rt, imm};
            4'd2:    encoded = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd3:    encoded = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd4:    encoded = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd5:    encoded = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd6:    encoded = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd7:    encoded = {6'b001000, rs, rt, imm};
            4'd8:    encoded = {6'b000100, rs, rt, imm};
            4'd9:    encoded = {6'b000010, target};
            default: encoded = 32'h0000_0000;
        endcase
    end

    // start wins over everything, so the handshake is closed in a start cycle
    assign in_ready  = (state_q == LOAD) && !start;
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + 1'b1;

`ifdef ENC_ILLEGAL_TRAP_EN
    logic legal;
    logic err_q, err_d;

    assign legal    = (kind <= 4'd9);
    assign write_en = accept && legal;

    // Sticky trap flag: set by an accepted illegal kind, cleared only by start
    always_comb begin
        err_d = err_q;
        if (start) begin
            err_d = 1'b0;
        end else if (accept && !legal) begin
            err_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign write_en = accept;
    assign err      = 1'b0;
`endif

    // Next-state and write-request logic; the write strobe defaults low each cycle
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        if (start) begin
            state_d = LOAD;
            count_d = '0;
        end else if (write_en) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = encoded;
            count_d = count_inc;
            if (count_inc == DEPTH_CNT) begin
                state_d = FULL;
            end
        end
    end

    // State, write port and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (count_q == DEPTH_CNT);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a 4-word memory (ADDR_W=2).
module tb_instr_encoder_loader;

    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        kind;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int testsRun = 0;
    int testsFailed = 0;

    instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .kind(kind),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .imm(imm),
        .target(target),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .count(count),
        .full(full),
        .err(err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic s, input logic v, input logic [3:0] k,
                                 input logic [4:0] r_s, input logic [4:0] r_t,
                                 input logic [4:0] r_d, input logic [15:0] im,
                                 input logic [25:0] tg);
        start    = s;
        in_valid = v;
        kind     = k;
        rs       = r_s;
        rt       = r_t;
        rd       = r_d;
        imm      = im;
        target   = tg;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_we"}, 32'(imem_we), 32'd0);
        checkOutput({tag, "_addr"}, 32'(imem_addr), 32'd0);
        checkOutput({tag, "_wdata"}, imem_wdata, 32'd0);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_full"}, 32'(full), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Directed sequence: every expected word below is hand-encoded
    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        checkResetValues("reset");
        #10;
        rst_n = 1'b1;
        tick();
        checkOutput("idle_in_ready", 32'(in_ready), 32'd0);

        // start, then a single lw
        applyStimulus(1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        checkOutput("start_cycle_in_ready", 32'(in_ready), 32'd0);
        tick();
        applyStimulus(0, 1, 4'd0, 5'd8, 5'd9, 5'd0, 16'h0004, 26'h0);
        checkOutput("load_in_ready", 32'(in_ready), 32'd1);
        tick();
        applyStimulus(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        checkOutput("lw_we", 32'(imem_we), 32'd1);
        checkOutput("lw_addr", 32'(imem_addr), 32'd0);
        checkOutput("lw_wdata", imem_wdata, 32'h8D09_0004);
        checkOutput("lw_count", 32'(count), 32'd1);
        tick();
        checkOutput("lw_we_one_cycle", 32'(imem_we), 32'd0);

        // restart, then four back-to-back words fill the memory
        applyStimulus(1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        checkOutput("restart_count", 32'(count), 32'd0);
        applyStimulus(0, 1, 4'd2, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0);
        tick();
        checkOutput("add_we", 32'(imem_we), 32'd1);
        checkOutput("add_addr", 32'(imem_addr), 32'd0);
        checkOutput("add_wdata", imem_wdata, 32'h0109_5020);
        applyStimulus(0, 1, 4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        tick();
        checkOutput("beq_we", 32'(imem_we), 32'd1);
        checkOutput("beq_addr", 32'(imem_addr), 32'd1);
        checkOutput("beq_wdata", imem_wdata, 32'h1022_FFFF);
        applyStimulus(0, 1, 4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010);
        tick();
        checkOutput("j_we", 32'(imem_we), 32'd1);
        checkOutput("j_addr", 32'(imem_addr), 32'd2);
        checkOutput("j_wdata", imem_wdata, 32'h0800_0010);
        checkOutput("j_count", 32'(count), 32'd3);
        checkOutput("j_full", 32'(full), 32'd0);
        applyStimulus(0, 1, 4'd5, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0);
        tick();
        checkOutput("or_we", 32'(imem_we), 32'd1);
        checkOutput("or_addr", 32'(imem_addr), 32'd3);
        checkOutput("or_wdata", imem_wdata, 32'h0064_2825);
        checkOutput("fill_count", 32'(count), 32'd4);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("full_no_we", 32'(imem_we), 32'd0);
        checkOutput("full_count_hold", 32'(count), 32'd4);

        // start from FULL clears and the next write lands at address 0
        applyStimulus(1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        checkOutput("refill_count", 32'(count), 32'd0);
        checkOutput("refill_full", 32'(full), 32'd0);
        applyStimulus(0, 1, 4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        checkOutput("refill_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("sub_addr", 32'(imem_addr), 32'd0);
        checkOutput("sub_wdata", imem_wdata, 32'h0022_1822);
        checkOutput("sub_count", 32'(count), 32'd1);

        // illegal kind
        applyStimulus(0, 1, 4'hF, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0);
        tick();
        applyStimulus(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
`ifdef ENC_ILLEGAL_TRAP_EN
        checkOutput("illegal_we", 32'(imem_we), 32'd0);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_count", 32'(count), 32'd1);
`else
        checkOutput("illegal_we", 32'(imem_we), 32'd1);
        checkOutput("illegal_addr", 32'(imem_addr), 32'd1);
        checkOutput("illegal_wdata", imem_wdata, 32'h0000_0000);
        checkOutput("illegal_err", 32'(err), 32'd0);
        checkOutput("illegal_count", 32'(count), 32'd2);
`endif

        // start together with a valid request: nothing accepted
        applyStimulus(1, 1, 4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        checkOutput("start_valid_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("start_valid_no_we", 32'(imem_we), 32'd0);
        checkOutput("start_valid_count", 32'(count), 32'd0);
        checkOutput("start_clears_err", 32'(err), 32'd0);

        // slt, addi, then sw interrupted by reset
        applyStimulus(0, 1, 4'd6, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
        tick();
        checkOutput("slt_addr", 32'(imem_addr), 32'd0);
        checkOutput("slt_wdata", imem_wdata, 32'h00A6_382A);
        applyStimulus(0, 1, 4'd7, 5'd0, 5'd1, 5'd0, 16'h8000, 26'h0);
        tick();
        checkOutput("addi_addr", 32'(imem_addr), 32'd1);
        checkOutput("addi_wdata", imem_wdata, 32'h2001_8000);
        applyStimulus(0, 1, 4'd1, 5'd29, 5'd31, 5'd0, 16'h0010, 26'h0);
        tick();
        checkOutput("sw_wdata", imem_wdata, 32'hAFBF_0010);
        checkOutput("sw_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        tick();
        checkOutput("reset_hold_we", 32'(imem_we), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_idle_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("post_reset_idle_we", 32'(imem_we), 32'd0);
        checkOutput("post_reset_idle_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
